// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_scan_ctrl_pkg: shared states, segment codes and digit helpers for the scan controller
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    localparam int N_DIGITS = 4;

    // Segment codes, bit0 = a ... bit6 = g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bit i set when digit i and every higher digit are zero; digit 0 is never blankable
    function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] digits);
        lz_mask = '0;
        lz_mask[N_DIGITS-1] = (digits[4*N_DIGITS-1 -: 4] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 1; i--)
            lz_mask[i] = lz_mask[i+1] && (digits[4*i +: 4] == 4'd0);
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: host-side control/data and display-side outputs of the scan controller
interface seven_seg_scan_ctrl_if;
    import seven_seg_scan_ctrl_pkg::*;

    logic                    enable;
    logic                    load;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    lz_blank_in;
    logic [N_DIGITS-1:0]     an_n;
    logic [7:0]              segment;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in, dp_in, lz_blank_in,
        input  an_n, segment, pending, frame_done
    );

    modport slave (
        input  enable, load, digits_in, dp_in, lz_blank_in,
        output an_n, segment, pending, frame_done
    );

endinterface

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: BCD digit to 7-segment pattern, non-decimal codes go dark
module seven_seg_decode
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Lookup table for 0-9, anything else blank
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed 4-digit 7-segment driver with dead time and frame-synchronous updates
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int DEAD    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
    localparam logic [1:0]    IDX_LAST  = 2'(N_DIGITS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [1:0]             r_idx;
    logic [1:0]             w_idx_nxt;

    logic [4*N_DIGITS-1:0]  r_sh_digits;
    logic [N_DIGITS-1:0]    r_sh_dp;
    logic                   r_sh_lz;
    logic [4*N_DIGITS-1:0]  r_act_digits;
    logic [N_DIGITS-1:0]    r_act_dp;
    logic                   r_act_lz;
    logic                   r_pending;

    logic [N_DIGITS-1:0]    r_an_n;
    logic [7:0]             r_segment;
    logic                   r_frame_done;

    logic                   w_boundary;
    logic                   w_lit;
    logic [3:0]             w_bcd;
    logic [6:0]             w_dec;
    logic [N_DIGITS-1:0]    w_lz_mask;
    logic                   w_blank_digit;

    assign w_boundary    = (r_state == SHOW) && (r_idx == IDX_LAST) && (r_cnt == CNT_LAST);
    assign w_lit         = (r_state == SHOW) && bus.enable;
    assign w_bcd         = r_act_digits[{r_idx, 2'b00} +: 4];
    assign w_lz_mask     = lz_mask(r_act_digits);
    assign w_blank_digit = r_act_lz && w_lz_mask[r_idx];

    seven_seg_decode u_decode (
        .i_bcd (w_bcd),
        .o_seg (w_dec)
    );

    // Scan sequencer: slot counter runs through dead time then lit time, digit index advances per slot
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                BLANK: begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = (r_cnt == DEAD_LAST) ? SHOW : BLANK;
                end
                SHOW: begin
                    w_cnt_nxt   = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                    w_idx_nxt   = (r_cnt == CNT_LAST) ? r_idx + 1'b1 : r_idx;
                    w_state_nxt = (r_cnt == CNT_LAST) ? BLANK : SHOW;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Shadow captures every load; active only changes at a frame boundary so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_lz      <= 1'b0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_lz     <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (bus.load) begin
                r_sh_digits <= bus.digits_in;
                r_sh_dp     <= bus.dp_in;
                r_sh_lz     <= bus.lz_blank_in;
            end
            if (w_boundary) begin
                if (bus.load) begin
                    r_act_digits <= bus.digits_in;
                    r_act_dp     <= bus.dp_in;
                    r_act_lz     <= bus.lz_blank_in;
                end else if (r_pending) begin
                    r_act_digits <= r_sh_digits;
                    r_act_dp     <= r_sh_dp;
                    r_act_lz     <= r_sh_lz;
                end
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Registered display outputs; enable gates them so the display goes dark on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n       <= '1;
            r_segment    <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_an_n       <= w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
            r_segment    <= w_lit ? {r_act_dp[r_idx], w_blank_digit ? SEG_BLANK : w_dec} : 8'h00;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.an_n       = r_an_n;
    assign bus.segment    = r_segment;
    assign bus.pending    = r_pending;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: scoreboard bench, CLK_DIV=8 DEAD=2, expected digit slots queued per frame
module tb_seven_seg_scan_ctrl;
    import seven_seg_scan_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if bus();

    seven_seg_scan_ctrl #(.CLK_DIV(8), .DEAD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         watch_pending = 1'b0;

    logic [3:0] prev_an = 4'hF;
    int         run = 0;
    int         gap = 0;
    int         fd_cnt = 0;
    bit         have_lit = 1'b0;
    bit         have_fd = 1'b0;
    exp_t       e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        exp_q.push_back(exp_t'{an: 4'hE, seg: s0});
        exp_q.push_back(exp_t'{an: 4'hD, seg: s1});
        exp_q.push_back(exp_t'{an: 4'hB, seg: s2});
        exp_q.push_back(exp_t'{an: 4'h7, seg: s3});
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        bus.digits_in   = d;
        bus.dp_in       = dp;
        bus.lz_blank_in = lz;
        bus.load        = 1'b1;
        @(negedge clk);
        bus.load        = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_done;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_done_timeout: got none, expected a pulse within 200 cycles");
        end
    endtask

    task automatic wait_an(input logic [3:0] a);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.an_n == a);
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL an_timeout: got none, expected an_n=%0h within 200 cycles", a);
        end
    endtask

    // Monitor: pops one expectation per lit slot, checks slot/gap lengths and frame period
    initial forever begin
        @(negedge clk);
        if (!rst_n || !bus.enable) begin
            have_lit = 1'b0;
            have_fd  = 1'b0;
            run      = 0;
            gap      = 0;
            fd_cnt   = 0;
        end else begin
            if (bus.an_n != 4'hF && prev_an == 4'hF) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_slot: got an_n=%0h seg=%0h, expected none", bus.an_n, bus.segment);
                end else begin
                    e = exp_q.pop_front();
                    check("slot_an", 32'(bus.an_n), 32'(e.an));
                    check("slot_seg", 32'(bus.segment), 32'(e.seg));
                end
                if (have_lit) check("dark_gap_len", gap, 2);
                run = 1;
            end else if (bus.an_n != 4'hF) begin
                run++;
            end else if (prev_an != 4'hF) begin
                check("lit_run_len", run, 6);
                have_lit = 1'b1;
                gap = 1;
            end else begin
                gap++;
            end
            fd_cnt++;
            if (bus.frame_done) begin
                if (have_fd) check("frame_period", fd_cnt, 32);
                have_fd = 1'b1;
                fd_cnt  = 0;
            end
        end
        if (watch_pending) check("pending_stays_low", 32'(bus.pending), 0);
        prev_an = bus.an_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.digits_in   = '0;
        bus.dp_in       = '0;
        bus.lz_blank_in = 1'b0;
        #23;
        check("rst_an", 32'(bus.an_n), 32'hF);
        check("rst_seg", 32'(bus.segment), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);

        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        bus.enable = 1'b1;
        wait_frame();

        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        repeat (5) @(negedge clk);
        do_load(16'h1234, 4'b0100, 1'b0);
        check("pending_after_load", 32'(bus.pending), 1);
        wait_frame();
        check("pending_cleared", 32'(bus.pending), 0);

        push_frame(8'h66, 8'h4F, 8'hDB, 8'h06);
        repeat (5) @(negedge clk);
        do_load(16'h0070, 4'b0000, 1'b1);
        wait_frame();

        push_frame(8'h3F, 8'h07, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        do_load(16'h0070, 4'b0000, 1'b0);
        wait_frame();

        push_frame(8'h3F, 8'h07, 8'h3F, 8'h3F);
        repeat (5) @(negedge clk);
        bus.digits_in   = 16'h9999;
        bus.dp_in       = 4'b1111;
        bus.lz_blank_in = 1'b1;
        bus.load        = 1'b1;
        @(negedge clk);
        do_load(16'h00AF, 4'b0011, 1'b0);
        check("pending_back_to_back", 32'(bus.pending), 1);
        wait_frame();

        push_frame(8'h80, 8'h80, 8'h3F, 8'h3F);
        repeat (31) @(negedge clk);
        watch_pending = 1'b1;
        do_load(16'h5678, 4'b0001, 1'b0);
        check("fd_with_boundary_load", 32'(bus.frame_done), 1);
        push_frame(8'hFF, 8'h07, 8'h7D, 8'h6D);
        repeat (4) @(negedge clk);
        watch_pending = 1'b0;

        wait_an(4'hE);
        do_load(16'h0001, 4'b0000, 1'b0);
        bus.enable = 1'b0;
        @(negedge clk);
        check("disable_an", 32'(bus.an_n), 32'hF);
        check("disable_seg", 32'(bus.segment), 0);
        check("disable_pending_kept", 32'(bus.pending), 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_frame(8'hFF, 8'h07, 8'h7D, 8'h6D);
        bus.enable = 1'b1;
        wait_frame();
        check("pending_after_reenable", 32'(bus.pending), 0);

        push_frame(8'h06, 8'h3F, 8'h3F, 8'h3F);
        wait_an(4'hE);
        do_load(16'h4444, 4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(bus.an_n), 32'hF);
        check("async_rst_seg", 32'(bus.segment), 0);
        check("async_rst_pending", 32'(bus.pending), 0);
        check("async_rst_frame_done", 32'(bus.frame_done), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        rst_n = 1'b1;
        wait_frame();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
